// File: rtl/rtf_uart_tx.sv
// rtl/rtf_uart_tx.sv - bus-attached UART transmitter with 8-entry TX FIFO (optional parity via RTF_UART_TX_PARITY_EN)
module rtf_uart_tx #(
    parameter logic [25:0] BASE        = 26'h00000CF,
    parameter logic [15:0] DIV_DEFAULT = 16'd433
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [33:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        txd_o,
    output logic        irq_o
);

`ifdef RTF_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_PAR   = 3'd4
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
    } tx_state_t;
`endif

    // bus decode
    logic        cs;
    logic        acc;
    logic        wr;
    logic        rd;
    logic [1:0]  reg_sel;
    logic        wr0;
    logic        rd0;
    logic [31:0] rdata;

    // control/status registers
    logic [15:0] divisor;
    logic        ien;
    logic        ovf;

    // FIFO
    logic [7:0]  mem [0:7];
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        push_ok;
    logic        pop;
    logic [7:0]  fifo_q;

    // transmitter
    tx_state_t   state;
    tx_state_t   state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [2:0]  bit_cnt;
    logic [2:0]  bit_n;
    logic [7:0]  shift;
    logic [7:0]  shift_n;
    logic        par;
    logic        par_n;
    logic        txd_n;
    logic        tick;
    logic        busy;

    // bits of the bus that carry no meaning for this block
    logic unused_ok;
    assign unused_ok = &{1'b0, sel_i[3:1], adr_i[7:4], adr_i[1:0], dat_i[31:16]};

    assign cs      = cyc_i & stb_i & (adr_i[33:8] == BASE);
    assign acc     = cs & ~ack_o;
    assign wr      = acc & we_i;
    assign rd      = acc & ~we_i;
    assign reg_sel = adr_i[3:2];
    assign wr0     = wr & (reg_sel == 2'd0);
    assign rd0     = rd & (reg_sel == 2'd0);

    assign empty   = (count == 4'd0);
    assign full    = (count == 4'd8);
    assign push_ok = wr0 & ~full;
    assign fifo_q  = mem[rd_ptr];

    assign busy    = (state != ST_IDLE);
    assign tick    = (cnt == 16'd0);

    // read-data mux for the addressed register
    always_comb begin
        rdata = 32'h0;
        case (reg_sel)
            2'd0:    rdata = {28'h0, ovf, busy, full, empty};
            2'd1:    rdata = {16'h0, divisor};
            2'd2:    rdata = {31'h0, ien};
            default: rdata = 32'h0;
        endcase
    end

    // bus acknowledge, read data capture and register writes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_o   <= 1'b0;
            dat_o   <= 32'h0;
            divisor <= DIV_DEFAULT;
            ien     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            ack_o <= acc;
            dat_o <= rd ? rdata : 32'h0;
            if (wr && reg_sel == 2'd1 && sel_i[0]) begin
                divisor <= dat_i[15:0];
            end
            if (wr && reg_sel == 2'd2) begin
                ien <= dat_i[0];
            end
            // a push into a full FIFO is lost even if the transmitter pops this cycle
            if (wr0 && full) begin
                ovf <= 1'b1;
            end else if (rd0) begin
                ovf <= 1'b0;
            end
        end
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= dat_i[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= 3'd0;
            rd_ptr <= 3'd0;
            count  <= 4'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 3'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 3'd1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // transmitter next-state, shift and bit-timer logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par;
        txd_n   = txd_o;
        pop     = 1'b0;
        // the divisor is sampled only at bit boundaries so a mid-frame write
        // never shortens or stretches the bit in progress
        if (state != ST_IDLE) begin
            cnt_n = tick ? divisor : (cnt - 16'd1);
        end
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_q;
                    par_n   = ^fifo_q;
                    cnt_n   = divisor;
                    txd_n   = 1'b0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    txd_n   = shift[0];
                    shift_n = {1'b0, shift[7:1]};
                    bit_n   = 3'd0;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt == 3'd7) begin
`ifdef RTF_UART_TX_PARITY_EN
                        txd_n   = par;
                        state_n = ST_PAR;
`else
                        txd_n   = 1'b1;
                        state_n = ST_STOP;
`endif
                    end else begin
                        txd_n   = shift[0];
                        shift_n = {1'b0, shift[7:1]};
                        bit_n   = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef RTF_UART_TX_PARITY_EN
            ST_PAR: begin
                if (tick) begin
                    txd_n   = 1'b1;
                    state_n = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    // chain straight into the next start bit when data is waiting
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_q;
                        par_n   = ^fifo_q;
                        txd_n   = 1'b0;
                        state_n = ST_START;
                    end else begin
                        txd_n   = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                txd_n   = 1'b1;
                state_n = ST_IDLE;
            end
        endcase
    end

    // transmitter state register; txd_o is registered for a glitch-free line
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cnt     <= 16'd0;
            bit_cnt <= 3'd0;
            shift   <= 8'h0;
            par     <= 1'b0;
            txd_o   <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            par     <= par_n;
            txd_o   <= txd_n;
        end
    end

    // level interrupt: transmitter fully drained, one cycle of latency
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= ien & empty & ~busy;
        end
    end

endmodule

// File: tb/tb_rtf_uart_tx.sv
// tb/tb_rtf_uart_tx.sv - directed self-checking bench for rtf_uart_tx
module tb_rtf_uart_tx;

`ifdef RTF_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam logic [25:0] BASE = 26'h00000CF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [33:0] adr = 34'h0;
    logic [31:0] dat = 32'h0;
    logic [31:0] dat_o;
    logic        ack;
    logic        txd;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc_cnt = 0;

    rtf_uart_tx dut (
        .clk_i (clk),
        .rst_i (rst),
        .cyc_i (cyc),
        .stb_i (stb),
        .we_i  (we),
        .sel_i (sel),
        .adr_i (adr),
        .dat_i (dat),
        .dat_o (dat_o),
        .ack_o (ack),
        .txd_o (txd),
        .irq_o (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [25:0] base, input logic [1:0] rg, input logic [31:0] d,
                          input logic [3:0] s, input logic exp_ack);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = s; dat = d;
        adr = {base, 4'h0, rg, 2'b00};
        @(posedge clk); #1;
        chk("wr_ack", {63'h0, ack}, {63'h0, exp_ack});
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'hF;
    endtask

    task automatic bus_rd(input logic [1:0] rg, output logic [31:0] d);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0;
        adr = {BASE, 4'h0, rg, 2'b00};
        @(posedge clk); #1;
        chk("rd_ack", {63'h0, ack}, 64'h1);
        d = dat_o;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic rx_byte(input int p, output logic [7:0] b, output logic ok, output int unsigned t0);
        int n;
        ok = 1'b1;
        b  = 8'h0;
        n  = 0;
        while (txd === 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) ok = 1'b0;
        t0 = cyc_cnt;
        repeat (p / 2) @(posedge clk);
        #1;
        if (txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (p) @(posedge clk);
            #1;
            b[i] = txd;
        end
`ifdef RTF_UART_TX_PARITY_EN
        repeat (p) @(posedge clk);
        #1;
        if (txd !== ^b) ok = 1'b0;
`endif
        repeat (p) @(posedge clk);
        #1;
        if (txd !== 1'b1) ok = 1'b0;
    endtask

    logic [31:0] rv;
    logic [47:0] obs_line;
    logic [47:0] exp_line;
    logic [FRAME_BITS-1:0] fbits;
    logic [7:0]  rb;
    logic        rok;
    int unsigned t_now;
    int unsigned t_prev;
    int          zeros;

    initial begin
        // reset state
        #12;
        chk("rst_txd", {63'h0, txd}, 64'h1);
        chk("rst_ack", {63'h0, ack}, 64'h0);
        chk("rst_dat", {32'h0, dat_o}, 64'h0);
        chk("rst_irq", {63'h0, irq}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        bus_rd(2'd0, rv);
        chk("status_reset", {32'h0, rv}, 64'h1);
        chk("txd_idle", {63'h0, txd}, 64'h1);
        bus_rd(2'd1, rv);
        chk("div_reset", {32'h0, rv}, 64'd433);

        // ack lasts one cycle even when the cycle is held
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {BASE, 4'h0, 2'd2, 2'b00};
        @(posedge clk); #1;
        chk("hold_ack1", {63'h0, ack}, 64'h1);
        @(posedge clk); #1;
        chk("hold_ack0", {63'h0, ack}, 64'h0);
        chk("hold_dat0", {32'h0, dat_o}, 64'h0);
        cyc = 1'b0; stb = 1'b0;

        // divisor write masked by sel_i[0], reg 3 reads zero
        bus_wr(BASE, 2'd1, 32'h0000_0007, 4'hE, 1'b1);
        bus_rd(2'd1, rv);
        chk("div_sel_masked", {32'h0, rv}, 64'd433);
        bus_wr(BASE, 2'd1, 32'h0000_0003, 4'hF, 1'b1);
        bus_rd(2'd1, rv);
        chk("div_write", {32'h0, rv}, 64'd3);
        bus_wr(BASE, 2'd3, 32'hFFFF_FFFF, 4'hF, 1'b1);
        bus_rd(2'd3, rv);
        chk("reg3_zero", {32'h0, rv}, 64'h0);

        // one 0x41 frame at divisor 3: four clocks per bit
        fbits = '1;
        fbits[0] = 1'b0;
        for (int i = 0; i < 8; i++) fbits[1 + i] = rv[0] | (8'h41 >> i) & 8'h01 ? 1'b1 : 1'b0;
`ifdef RTF_UART_TX_PARITY_EN
        fbits[9] = 1'b0;
`endif
        fbits[FRAME_BITS-1] = 1'b1;
        exp_line = '1;
        for (int k = 0; k < FRAME_BITS * 4; k++) exp_line[k] = fbits[k / 4];
        bus_wr(BASE, 2'd0, 32'h0000_0041, 4'hF, 1'b1);
        for (int k = 0; k < 48; k++) begin
            @(posedge clk); #1;
            obs_line[k] = txd;
        end
        chk("frame_41", {16'h0, obs_line}, {16'h0, exp_line});
        bus_rd(2'd0, rv);
        chk("status_after_frame", {32'h0, rv}, 64'h1);

        // overflow: one byte in flight, then 00..08 queued
        bus_wr(BASE, 2'd1, 32'd9, 4'hF, 1'b1);
        bus_wr(BASE, 2'd0, 32'h0000_00FF, 4'hF, 1'b1);
        for (int i = 0; i < 9; i++) bus_wr(BASE, 2'd0, i, 4'hF, 1'b1);
        bus_rd(2'd0, rv);
        chk("status_full_ovf", {32'h0, rv}, 64'hE);
        bus_rd(2'd0, rv);
        chk("status_ovf_clr", {32'h0, rv}, 64'h6);
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            rx_byte(10, rb, rok, t_now);
            chk("rx_ok", {63'h0, rok}, 64'h1);
            chk("rx_byte", {56'h0, rb}, i);
            if (i > 0) chk("rx_no_gap", t_now - t_prev, FRAME_BITS * 10);
            t_prev = t_now;
        end
        zeros = 0;
        for (int k = 0; k < 3 * FRAME_BITS * 10; k++) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) zeros++;
        end
        chk("byte08_dropped", zeros, 0);
        bus_rd(2'd0, rv);
        chk("status_drained", {32'h0, rv}, 64'h1);

        // interrupt
        bus_wr(BASE, 2'd1, 32'd3, 4'hF, 1'b1);
        chk("irq_off", {63'h0, irq}, 64'h0);
        bus_wr(BASE, 2'd2, 32'd1, 4'hF, 1'b1);
        @(posedge clk); #1;
        chk("irq_on", {63'h0, irq}, 64'h1);
        bus_wr(BASE, 2'd0, 32'h0000_0055, 4'hF, 1'b1);
        @(posedge clk); #1;
        chk("irq_busy", {63'h0, irq}, 64'h0);
        repeat (FRAME_BITS * 4) @(posedge clk);
        #1;
        chk("irq_latency", {63'h0, irq}, 64'h0);
        @(posedge clk); #1;
        chk("irq_done", {63'h0, irq}, 64'h1);

        // reset mid-DATA with an all-zero byte on the line
        bus_wr(BASE, 2'd0, 32'h0000_0000, 4'hF, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        chk("pre_rst_txd", {63'h0, txd}, 64'h0);
        rst = 1'b1;
        #1;
        chk("async_rst_txd", {63'h0, txd}, 64'h1);
        chk("async_rst_irq", {63'h0, irq}, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus_rd(2'd0, rv);
        chk("status_post_rst", {32'h0, rv}, 64'h1);
        bus_rd(2'd1, rv);
        chk("div_post_rst", {32'h0, rv}, 64'd433);
        chk("txd_post_rst", {63'h0, txd}, 64'h1);

        // foreign base address is ignored
        bus_wr(26'h00000CE, 2'd1, 32'd5, 4'hF, 1'b0);
        bus_wr(26'h00000CE, 2'd0, 32'h0000_0055, 4'hF, 1'b0);
        @(posedge clk); #1;
        chk("foreign_ack", {63'h0, ack}, 64'h0);
        chk("foreign_txd", {63'h0, txd}, 64'h1);
        bus_rd(2'd1, rv);
        chk("foreign_div", {32'h0, rv}, 64'd433);
        bus_rd(2'd0, rv);
        chk("foreign_status", {32'h0, rv}, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rtf_uart_tx.md
RTF_UART_TX -- requirements
Module: rtf_uart_tx

Interface
REQ-001 Parameter BASE, 26'h00000CF: the block decodes when adr_i[33:8]==BASE.
REQ-002 Parameter DIV_DEFAULT, 16'd433: the reset value of the baud divisor.
REQ-003 Port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 Port cyc_i, input, 1: bus cycle valid.
REQ-006 Port stb_i, input, 1: strobe.
REQ-007 Port we_i, input, 1: write enable.
REQ-008 Port sel_i, input, 4: byte lane selects; ignored except as noted.
REQ-009 Port adr_i, input, 34: byte address.
REQ-010 Port dat_i, input, 32: write data.
REQ-011 Port dat_o, output, 32: read data; 0 when ack_o is low.
REQ-012 Port ack_o, output, 1: registered bus acknowledge.
REQ-013 Port txd_o, output, 1: serial output; idle high.
REQ-014 Port irq_o, output, 1: level interrupt request.

Function
REQ-015 Definition: cs = cyc_i & stb_i & (adr_i[33:8]==BASE); register select = adr_i[3:2].
REQ-016 Bus handshake:
- cs & ~ack_o at an edge sets ack_o for exactly one cycle.
- Any write side effect occurs on that same edge.
- ack_o clears on the next edge, even if cs remains high.
REQ-017 Reg 0 write: pushes dat_i[7:0] into an 8-entry TX FIFO.
REQ-018 Reg 0 read: returns {24'h0, 4'h0, ovf, busy, full, empty}.
REQ-019 A reg 0 read clears ovf on the ack edge.
REQ-020 Reg 1: divisor; R/W, 16 bits on dat[15:0]; a write updates it only when sel_i[0] is set.
REQ-021 Reg 2: control; bit0 = ien, R/W.
REQ-022 Reg 3: reads 0; writes are ignored.
REQ-023 FIFO: 3-bit read/write pointers wrap modulo 8; 4-bit count, 0..8.
- empty = (count==0); full = (count==8).
REQ-024 A push while full discards the byte and sets ovf; a pop in the same cycle does not make room.
REQ-025 A simultaneous push and pop when 0<count<8 leaves count unchanged.
REQ-026 TX FSM states are IDLE, START, DATA, (PAR), STOP.
- In IDLE, if the FIFO is not empty: pop into the shift register, go to START.
REQ-027 Each serial bit lasts exactly divisor+1 clocks, timed by a down-counter reloaded at every bit boundary.
REQ-028 START drives txd_o=0.
REQ-029 DATA sends 8 bits LSB first, using a 3-bit bit counter.
REQ-030 STOP drives txd_o=1 for one bit time, then:
- goes back to START with the next byte if the FIFO is not empty, or
- goes to IDLE if it is empty.
There is no extra idle bit between frames.
REQ-031 busy = (state != IDLE).
REQ-032 A divisor write mid-frame takes effect at the next bit boundary.
REQ-033 irq_o = ien & empty & ~busy, registered so it has one cycle of latency.
REQ-034 txd_o is driven from a register, so the output is glitch-free.

Reset
REQ-035 Reset sets:
- ack_o=0, dat_o=0, txd_o=1, irq_o=0
- FIFO empty, pointers 0, ovf=0
- state=IDLE, divisor=DIV_DEFAULT, ien=0
REQ-036 Reset asserted mid-frame aborts the frame immediately and drives txd_o high; queued bytes are lost.

Configuration
REQ-037 Macro RTF_UART_TX_PARITY_EN:
- Defined: an even-parity bit (XOR of the 8 data bits) is sent in state PAR between DATA and STOP; a frame is 11 bit times.
- Undefined: PAR does not exist and frames are 8N1 (10 bit times).

Verification
REQ-038 Reset, then read reg 0 -> ack_o one cycle later, dat_o=32'h1; txd_o=1.
REQ-039 Write reg1=3, write reg0=8'h41 -> txd_o shows 4 clocks each of 0, then 1,0,0,0,0,0,1,0, then 1; the frame totals 40 clocks (44 with the parity macro, parity bit=0).
REQ-040 Nine back-to-back writes 8'h00..8'h08 while the divisor is large -> status reads full=1, ovf=1.
- The first eight bytes are sent in order with no idle gap between frames.
- Byte 8'h08 is never sent.
- A second status read shows ovf=0.
REQ-041 Write reg2=1 with the FIFO idle -> irq_o=1; write a byte -> irq_o=0 while busy; irq_o=1 again after the stop bit.
REQ-042 Assert rst_i mid-DATA -> txd_o=1 and state IDLE asynchronously; after release, status reads 32'h1.
REQ-043 Access with adr_i[33:8]!=BASE -> ack_o stays 0 and no state changes.
